uart_line_rx: RTL
=================

// Module: uart_line_rx
// PURPOSE
//  Line assembler on the receive side of the UART link (115200 8N1 core).
//  Consumes the byte stream from uart_rx (rx_data/rx_done) and collects
//  printable text up to a CR/LF terminator into an internal line buffer.
//  Holds the completed line for a host or CPU to read by address, then
//  releases it on line_ack. Command-line front end for the FPGA debug console.
// PARAMETERS
//  DEPTH    32     max characters per line (power of 2, >=4)
//  AW       5      buffer address width, = $clog2(DEPTH)
// PORTS
//  clk         in   1     system clock
//  rst         in   1     reset, synchronous, active-high
//  rx_data     in   8     received byte from uart_rx
//  rx_done     in   1     1-cycle strobe: rx_data valid
//  line_ready  out  1     completed line held in buffer
//  line_len    out  AW+1  char count of held line (0..DEPTH)
//  rd_addr     in   AW    buffer read address
//  rd_data     out  8     buffer byte at rd_addr, 1-cycle latency
//  line_ack    in   1     host done with line; release buffer
//  overflow    out  1     held/filling line lost chars (sticky per line)
//  dropped     out  1     1-cycle pulse: byte discarded while line_ready
// BEHAVIOUR
//  Reset: state=FILL, count=0, line_ready=0, line_len=0, overflow=0,
//   dropped=0, rd_data=8'h00. Buffer contents are not cleared.
//  States: FILL, READY.
//  FILL, rx_done=1, classify rx_data:
//   - 8'h0D or 8'h0A: if count==0 ignore (CRLF pair / empty line produces
//     no line); else line_len<=count, line_ready<=1 next cycle, ->READY.
//   - 8'h08 (BS): if count>0 count<=count-1; else ignore. No store.
//   - other, count<DEPTH: buf[count]<=rx_data, count<=count+1.
//   - other, count==DEPTH: byte discarded, overflow<=1.
//  READY: buffer and line_len frozen.
//   - rx_done=1: byte discarded, dropped=1 for exactly that cycle +1.
//   - line_ack=1: next cycle line_ready=0, line_len=0, count=0,
//     overflow=0, ->FILL.
//   - rx_done & line_ack same cycle: ack wins, byte discarded, dropped
//     pulses; next byte after that cycle is accepted normally.
//  line_ack in FILL: ignored.
//  rd_data <= buf[rd_addr] every cycle, any state; registered (1 cycle).
//   Reading addresses >= line_len returns stale contents, not an error.
//  count width AW+1; never exceeds DEPTH; no wrap-around.
//  rst mid-line (any state): partial line discarded, outputs to reset values.
//  No parity/framing handling here; uart_rx owns line errors.
// TESTING
//  1 rst 5 cyc; send "UART IP TEST\r\n" via uart_tx->uart_rx -> line_ready=1,
//    line_len=12, rd_addr 0..11 -> 55 41 52 54 20 49 50 20 54 45 53 54.
//  2 send "\r\n\r\n" only -> line_ready stays 0, count stays 0.
//  3 DEPTH=8, send "ABCDEFGHIJ\n" -> line_len=8, overflow=1,
//    rd 0..7 = 41..48; after line_ack overflow=0, line_len=0.
//  4 line held; inject rx_done with 8'h5A -> dropped 1-cycle pulse,
//    line_len and buf unchanged; assert line_ack same cycle as rx_done
//    -> FILL next cycle, dropped pulses, following "OK\n" -> len 2.
//  5 send "AB\x08C\n" -> line_len=2, rd 0,1 = 41 43; "\x08\x08X\n" -> len 1.
//  6 send "ABC", pulse rst 1 cyc, send "Q\n" -> line_len=1, rd 0 = 51.

Source files
------------

// File: rtl/uart_line_rx.sv
// Receive-side line assembler: collects printable bytes from uart_rx up to CR/LF
// and holds the completed line for random-access reads until line_ack.
module uart_line_rx #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_done,
    output logic          line_ready,
    output logic [AW:0]   line_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          line_ack,
    output logic          overflow,
    output logic          dropped
);

    typedef enum logic {FILL, READY} state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    state_t        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   len_q, len_d;
    logic          ovf_q, ovf_d;
    logic          drop_q, drop_d;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            count_q <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        drop_d  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = count_q[AW-1:0];
        case (state_q)
            FILL: begin
                if (rx_done) begin
                    if (rx_data == 8'h0D || rx_data == 8'h0A) begin
                        // A terminator on an empty line (second half of CRLF) is swallowed
                        if (count_q != '0) begin
                            len_d   = count_q;
                            state_d = READY;
                        end
                    end else if (rx_data == 8'h08) begin
                        if (count_q != '0)
                            count_d = count_q - ONE_C;
                    end else if (count_q < DEPTH_C) begin
                        wr_en   = 1'b1;
                        count_d = count_q + ONE_C;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            READY: begin
                drop_d = rx_done;
                // Ack takes priority; a byte arriving with it is still discarded
                if (line_ack) begin
                    state_d = FILL;
                    count_d = '0;
                    len_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Buffer RAM is intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_en && !rst)
            mem[wr_addr] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= 8'h00;
        else
            rd_data <= mem[rd_addr];
    end

    assign line_ready = (state_q == READY);
    assign line_len   = len_q;
    assign overflow   = ovf_q;
    assign dropped    = drop_q;

endmodule
